ram_access_ctrl: RTL and testbench

//  Initiator side of the 64x16 single-port RAM interface (add/data_in/r_w/enable/ce, registered data_out).

---
 rtl/ram_access_ctrl_pkg.sv | 25 ++
 rtl/ram_access_ctrl_if.sv | 59 +++++
 rtl/ram_access_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ram_access_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram_ctrl_pkg
//   Shared definitions for the RAM access controller: default geometry of the
//   64x16 single-port RAM and the controller state encoding.
//   Optional feature macro used by the files importing this package:
//     RAM_ACC_HALF_EN - adds 16-bit (halfword) accesses via req_half.
// ---------------------------------------------------------------------------
package ram_ctrl_pkg;

    localparam int RAM_AW_DEF = 6;   // halfword address width
    localparam int RAM_DW_DEF = 16;  // RAM word width

    // Controller states. A 32-bit access walks both halves of a word pair;
    // reads need one extra state because the RAM output is registered.
    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_HI,
        RD_DONE,
        RESP
    } ram_ctrl_state_t;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram_access_ctrl_if
//   Core-side request/response channels of the RAM access controller.
//   Two independent valid/ready handshakes:
//     request : req_valid/req_ready, req_we, req_addr, req_wdata
//               (+ req_half when RAM_ACC_HALF_EN is defined)
//     response: rsp_valid/rsp_ready, rsp_rdata
//   Modports:
//     master - the core (LSU) side, drives requests and accepts responses
//     slave  - the controller side
// ---------------------------------------------------------------------------
interface ram_access_ctrl_if
    import ram_ctrl_pkg::*;
#(
    parameter int RAM_AW = RAM_AW_DEF,
    parameter int RAM_DW = RAM_DW_DEF
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [RAM_AW-1:0]     req_addr;
    logic [2*RAM_DW-1:0]   req_wdata;
`ifdef RAM_ACC_HALF_EN
    logic                  req_half;
`endif
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*RAM_DW-1:0]   rsp_rdata;

    modport master (
`ifdef RAM_ACC_HALF_EN
        output req_half,
`endif
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
`ifdef RAM_ACC_HALF_EN
        input  req_half,
`endif
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );

endinterface

// File: rtl/ram_access_ctrl.sv
// ---------------------------------------------------------------------------
// ram_access_ctrl
//   Initiator for a single-port RAM of 2**RAM_AW words x RAM_DW bits with a
//   registered data output. Each 32-bit core access becomes two RAM cycles:
//   low half at the even halfword address, high half at the odd one. Read
//   data is reassembled and returned on the response handshake; stores also
//   respond, with zero data.
//
//   Optional feature (macro RAM_ACC_HALF_EN): req_half selects a 16-bit
//   access that uses req_addr unmodified and a single RAM cycle.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : synchronous reset, active low; aborts any access at once
//   bus          : ram_access_ctrl_if.slave (request/response handshakes)
//   ram_add      : RAM halfword address
//   ram_data_in  : RAM write data
//   ram_r_w      : 1 = write, 0 = read
//   ram_enable   : RAM enable
//   ram_ce       : RAM chip enable
//   ram_data_out : RAM read data, valid the cycle after a read cycle
//
// Latency from the accept cycle (0) to rsp_valid:
//   32-bit store 3, 32-bit load 4, half store 2, half load 3.
// ---------------------------------------------------------------------------
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int RAM_AW = RAM_AW_DEF,
    parameter int RAM_DW = RAM_DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ram_access_ctrl_if.slave     bus,
    output logic [RAM_AW-1:0]    ram_add,
    output logic [RAM_DW-1:0]    ram_data_in,
    output logic                 ram_r_w,
    output logic                 ram_enable,
    output logic                 ram_ce,
    input  logic [RAM_DW-1:0]    ram_data_out
);

    ram_ctrl_state_t       state;

    // Request latches. Only the parts needed after the first RAM cycle are
    // kept: the first cycle is issued straight from the request fields.
    logic [RAM_AW-1:1]     addr_q;
    logic [RAM_DW-1:0]     wdata_hi_q;
    logic                  we_q;
    logic                  half_q;

    logic [2*RAM_DW-1:0]   rdata_q;
    logic                  rsp_valid_q;
    logic                  ready_q;

    // Registered RAM pins, loaded with the values of the state being entered.
    logic [RAM_AW-1:0]     ram_add_q;
    logic [RAM_DW-1:0]     ram_din_q;
    logic                  ram_rw_q;
    logic                  ram_en_q;

    logic                  req_half_in;
    logic [RAM_AW-1:0]     acc_addr;

`ifdef RAM_ACC_HALF_EN
    assign req_half_in = bus.req_half;
`else
    assign req_half_in = 1'b0;
`endif

    // 32-bit accesses are word-pair aligned; halfword accesses keep bit 0.
    assign acc_addr = req_half_in ? bus.req_addr
                                  : {bus.req_addr[RAM_AW-1:1], 1'b0};

    // Enables are qualified with rst_n so a reset arriving during a RAM cycle
    // suppresses that cycle instead of letting it complete at the same edge.
    assign ram_add     = ram_add_q;
    assign ram_data_in = ram_din_q;
    assign ram_r_w     = ram_rw_q;
    assign ram_enable  = ram_en_q & rst_n;
    assign ram_ce      = ram_en_q & rst_n;

    // ready_q is 1 exactly in IDLE; gating with rst_n keeps it low in reset.
    assign bus.req_ready = ready_q & rst_n;
    assign bus.rsp_valid = rsp_valid_q;
    // Stores always respond with zero data.
    assign bus.rsp_rdata = we_q ? '0 : rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            addr_q      <= '0;
            wdata_hi_q  <= '0;
            we_q        <= 1'b0;
            half_q      <= 1'b0;
            ram_add_q   <= '0;
            ram_din_q   <= '0;
            ram_rw_q    <= 1'b0;
            ram_en_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        addr_q     <= bus.req_addr[RAM_AW-1:1];
                        wdata_hi_q <= bus.req_wdata[2*RAM_DW-1:RAM_DW];
                        we_q       <= bus.req_we;
                        half_q     <= req_half_in;
                        rdata_q    <= '0;
                        ready_q    <= 1'b0;
                        // First RAM cycle (low half, or the only half).
                        ram_en_q   <= 1'b1;
                        ram_rw_q   <= bus.req_we;
                        ram_add_q  <= acc_addr;
                        ram_din_q  <= bus.req_we ? bus.req_wdata[RAM_DW-1:0] : '0;
                        state      <= bus.req_we ? WR_LO : RD_LO;
                    end
                end

                WR_LO: begin
                    if (half_q) begin
                        ram_en_q    <= 1'b0;
                        ram_rw_q    <= 1'b0;
                        ram_add_q   <= '0;
                        ram_din_q   <= '0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        ram_add_q <= {addr_q, 1'b1};
                        ram_din_q <= wdata_hi_q;
                        state     <= WR_HI;
                    end
                end

                WR_HI: begin
                    ram_en_q    <= 1'b0;
                    ram_rw_q    <= 1'b0;
                    ram_add_q   <= '0;
                    ram_din_q   <= '0;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end

                RD_LO: begin
                    if (half_q) begin
                        ram_en_q  <= 1'b0;
                        ram_add_q <= '0;
                        state     <= RD_DONE;
                    end else begin
                        ram_add_q <= {addr_q, 1'b1};
                        state     <= RD_HI;
                    end
                end

                // Low-half data from RD_LO appears on ram_data_out now.
                RD_HI: begin
                    rdata_q[RAM_DW-1:0] <= ram_data_out;
                    ram_en_q            <= 1'b0;
                    ram_add_q           <= '0;
                    state               <= RD_DONE;
                end

                // Data of the last read cycle; for a half load that is the
                // only half, and the upper half stays zero from acceptance.
                RD_DONE: begin
                    if (half_q) begin
                        rdata_q[RAM_DW-1:0] <= ram_data_out;
                    end else begin
                        rdata_q[2*RAM_DW-1:RAM_DW] <= ram_data_out;
                    end
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    ram_en_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_access_ctrl
//   Bench for ram_access_ctrl. A behavioural 64x16 RAM with registered read
//   data sits on the RAM pins; a separate reference memory tracks what the
//   RAM must contain from the access rules alone. Directed cases are
//   followed by randomized traffic. Half accesses are exercised when
//   RAM_ACC_HALF_EN is defined.
// ---------------------------------------------------------------------------
module tb_ram_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic [5:0]  ram_add;
    logic [15:0] ram_data_in;
    logic        ram_r_w;
    logic        ram_enable;
    logic        ram_ce;
    logic [15:0] ram_data_out;

    logic [15:0] ram_mem [64];
    bit   [15:0] ref_mem [64];

    int n_chk;
    int n_err;

    ram_access_ctrl_if #(.RAM_AW(6), .RAM_DW(16)) bus ();

    ram_access_ctrl #(.RAM_AW(6), .RAM_DW(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .ram_add      (ram_add),
        .ram_data_in  (ram_data_in),
        .ram_r_w      (ram_r_w),
        .ram_enable   (ram_enable),
        .ram_ce       (ram_ce),
        .ram_data_out (ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: write on r_w=1, registered read on r_w=0.
    always @(posedge clk) begin
        if (ram_enable && ram_ce) begin
            if (ram_r_w) ram_mem[ram_add] <= ram_data_in;
            else         ram_data_out     <= ram_mem[ram_add];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One complete transaction; expectations come from the reference memory.
    task automatic xact(input bit we, input bit [5:0] addr, input bit [31:0] wdata,
                        input bit half, input int hold);
        bit [5:0]    a0;
        bit [31:0]   exp_rd;
        int          exp_lat;
        int          cyc;
        logic [31:0] held;
        a0 = {addr[5:1], 1'b0};
        if (half) begin
            exp_lat = we ? 2 : 3;
            if (we) begin
                ref_mem[addr] = wdata[15:0];
                exp_rd = 32'h0;
            end else begin
                exp_rd = {16'h0, ref_mem[addr]};
            end
        end else begin
            exp_lat = we ? 3 : 4;
            if (we) begin
                ref_mem[a0]        = wdata[15:0];
                ref_mem[a0 | 6'd1] = wdata[31:16];
                exp_rd = 32'h0;
            end else begin
                exp_rd = {ref_mem[a0 | 6'd1], ref_mem[a0]};
            end
        end

        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
`ifdef RAM_ACC_HALF_EN
        bus.req_half  = half;
`endif
        bus.rsp_ready = (hold == 0);
        chk("req_ready_idle", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        // Fields may change once accepted.
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = 6'($urandom);
        bus.req_wdata = $urandom;
        cyc = 1;
        chk("req_ready_busy", bus.req_ready, 1'b0);
        while (!bus.rsp_valid && cyc < 16) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, exp_lat);
        chk("rsp_rdata", bus.rsp_rdata, exp_rd);
        held = bus.rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
            chk("bp_rsp_rdata", bus.rsp_rdata, held);
            chk("bp_req_ready", bus.req_ready, 1'b0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rsp_valid_drop", bus.rsp_valid, 1'b0);
        chk("req_ready_back", bus.req_ready, 1'b1);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [15:0] v;
        bit [15:0] old;
        bit        hf;
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) begin
            v = 16'($urandom);
            ram_mem[i] <= v;
            ref_mem[i] = v;
        end
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
`ifdef RAM_ACC_HALF_EN
        bus.req_half  = 1'b0;
`endif

        // Reset for two cycles.
        #1;
        chk("rst_req_ready_t0", bus.req_ready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_req_ready", bus.req_ready, 1'b0);
            chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
            chk("rst_ram_enable", ram_enable, 1'b0);
            chk("rst_ram_ce", ram_ce, 1'b0);
        end
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", bus.req_ready, 1'b1);
        chk("post_rst_rsp_rdata", bus.rsp_rdata, 32'h0);

        // Store then loads at the even and the odd address of the pair.
        xact(1'b1, 6'd6, 32'hDEADBEEF, 1'b0, 0);
        chk("ram6", ram_mem[6], 16'hBEEF);
        chk("ram7", ram_mem[7], 16'hDEAD);
        xact(1'b0, 6'd6, 32'h0, 1'b0, 0);
        xact(1'b0, 6'd7, 32'h0, 1'b0, 0);

        // Response backpressure.
        xact(1'b0, 6'd6, 32'h0, 1'b0, 5);
        xact(1'b1, 6'd20, 32'hCAFEF00D, 1'b0, 3);

        // Reset while the high half of a store is on the RAM pins.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 6'd10;
        bus.req_wdata = 32'h12345678;
        bus.rsp_ready = 1'b1;
        chk("abort_req_ready", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("abort_lo_add", ram_add, 6'd10);
        chk("abort_lo_din", ram_data_in, 16'h5678);
        chk("abort_lo_rw", ram_r_w, 1'b1);
        chk("abort_lo_en", ram_enable, 1'b1);
        @(posedge clk); #1;
        chk("abort_hi_add", ram_add, 6'd11);
        chk("abort_hi_din", ram_data_in, 16'h1234);
        rst_n = 1'b0;
        #1;
        chk("abort_en_gated", ram_enable, 1'b0);
        @(posedge clk); #1;
        chk("abort_rst_ready", bus.req_ready, 1'b0);
        chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
        chk("abort_ram_ce", ram_ce, 1'b0);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b0;
        #1;
        chk("abort_idle_ready", bus.req_ready, 1'b1);
        ref_mem[10] = 16'h5678;
        chk("abort_ram10", ram_mem[10], 16'h5678);
        chk("abort_ram11", ram_mem[11], ref_mem[11]);
        xact(1'b0, 6'd10, 32'h0, 1'b0, 0);

`ifdef RAM_ACC_HALF_EN
        // Halfword store and load at an odd address.
        old = ref_mem[2];
        xact(1'b1, 6'd3, 32'hAAAA5555, 1'b1, 0);
        chk("half_ram3", ram_mem[3], 16'h5555);
        chk("half_ram2", ram_mem[2], old);
        xact(1'b0, 6'd3, 32'h0, 1'b1, 0);
`endif

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            hf = 1'b0;
`ifdef RAM_ACC_HALF_EN
            hf = 1'($urandom);
`endif
            xact(1'($urandom), 6'($urandom), $urandom, hf, int'($urandom_range(0, 2)));
        end

        // Whole-memory comparison against the reference.
        for (int i = 0; i < 64; i++) begin
            chk("mem_final", ram_mem[i], ref_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
